// File: rtl/encode_stage_prefix_serializer_if.sv
// rtl/encode_stage_prefix_serializer_if.sv - request attribute and prefix byte stream bundle
interface encode_stage_prefix_serializer_if;
   logic       i_req_valid;
   logic       o_req_ready;
   logic       i_lock_bus;
   logic       i_repeat_not_equal;
   logic       i_repeat_equal;
   logic       i_segment_override;
   logic [2:0] i_segment_override_index;
   logic       i_hint_branch_not_taken;
   logic       i_hint_branch_taken;
   logic       i_operand_size;
   logic       i_address_size;
   logic       o_byte_valid;
   logic       i_byte_ready;
   logic [7:0] o_byte;
   logic       o_byte_last;
   logic       o_done;
   logic       o_error;
   logic [2:0] o_byte_count;

   // Producer of requests and consumer of prefix bytes
   modport master (
      output i_req_valid, i_lock_bus, i_repeat_not_equal, i_repeat_equal,
             i_segment_override, i_segment_override_index,
             i_hint_branch_not_taken, i_hint_branch_taken,
             i_operand_size, i_address_size, i_byte_ready,
      input  o_req_ready, o_byte_valid, o_byte, o_byte_last,
             o_done, o_error, o_byte_count
   );

   // The serializer itself
   modport slave (
      input  i_req_valid, i_lock_bus, i_repeat_not_equal, i_repeat_equal,
             i_segment_override, i_segment_override_index,
             i_hint_branch_not_taken, i_hint_branch_taken,
             i_operand_size, i_address_size, i_byte_ready,
      output o_req_ready, o_byte_valid, o_byte, o_byte_last,
             o_done, o_error, o_byte_count
   );
endinterface

// File: rtl/encode_stage_prefix_serializer.sv
// rtl/encode_stage_prefix_serializer.sv - serializes prefix attributes into IA-32 prefix bytes (optional PREFIX_ENCODER_BRANCH_HINT_EN)
module encode_stage_prefix_serializer (
   input logic i_clk,
   input logic i_rst_n,
   encode_stage_prefix_serializer_if.slave bus
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] EMIT = 1'b1;

   logic [0:0] state;
   logic [3:0] pending;
   logic [7:0] g1_byte;
   logic [7:0] g2_byte;
   logic [2:0] count;
   logic       done;
   logic       error;

   logic [1:0] g1_cnt;
   logic [7:0] g1_next;
   logic [7:0] seg_byte;
   logic [7:0] g2_next;
   logic       g2_present;
   logic       g2_err;
   logic [3:0] req_mask;
   logic       req_err;
   logic       accept;
   logic       handshake;
   logic       last;
   logic [7:0] cur_byte;

   // Translate the incoming attribute set into a group mask, group bytes and an error flag
   always_comb begin
      g1_cnt  = {1'b0, bus.i_lock_bus} + {1'b0, bus.i_repeat_not_equal} + {1'b0, bus.i_repeat_equal};
      g1_next = bus.i_lock_bus ? 8'hF0 : (bus.i_repeat_not_equal ? 8'hF2 : 8'hF3);
      case (bus.i_segment_override_index)
         3'd0:    seg_byte = 8'h26;
         3'd1:    seg_byte = 8'h2E;
         3'd2:    seg_byte = 8'h36;
         3'd3:    seg_byte = 8'h3E;
         3'd4:    seg_byte = 8'h64;
         3'd5:    seg_byte = 8'h65;
         default: seg_byte = 8'h00;
      endcase
`ifdef PREFIX_ENCODER_BRANCH_HINT_EN
      // Hints share group 2 with segment overrides, so they may not coexist
      g2_present = bus.i_segment_override | bus.i_hint_branch_not_taken | bus.i_hint_branch_taken;
      g2_err     = (bus.i_segment_override && (bus.i_segment_override_index[2:1] == 2'b11))
                 || (bus.i_hint_branch_not_taken && bus.i_hint_branch_taken)
                 || (bus.i_segment_override && (bus.i_hint_branch_not_taken || bus.i_hint_branch_taken));
      g2_next    = bus.i_hint_branch_taken ? 8'h3E :
                   (bus.i_hint_branch_not_taken ? 8'h2E : seg_byte);
`else
      g2_present = bus.i_segment_override;
      g2_err     = bus.i_segment_override && (bus.i_segment_override_index[2:1] == 2'b11);
      g2_next    = seg_byte;
`endif
      req_mask = {bus.i_address_size, bus.i_operand_size, g2_present, (g1_cnt != 2'd0)};
      req_err  = (g1_cnt > 2'd1) || g2_err;
   end

   assign accept    = bus.i_req_valid && (state == IDLE);
   assign handshake = (state == EMIT) && bus.i_byte_ready;
   assign last      = (pending != 4'd0) && ((pending & (pending - 4'd1)) == 4'd0);

   // Present the byte of the lowest-numbered group still pending
   always_comb begin
      cur_byte = 8'h00;
      if (pending[0])      cur_byte = g1_byte;
      else if (pending[1]) cur_byte = g2_byte;
      else if (pending[2]) cur_byte = 8'h66;
      else if (pending[3]) cur_byte = 8'h67;
   end

   // Request acceptance, byte-by-byte emission and completion reporting
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= IDLE;
         pending <= 4'd0;
         g1_byte <= 8'h00;
         g2_byte <= 8'h00;
         count   <= 3'd0;
         done    <= 1'b0;
         error   <= 1'b0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         if (accept) begin
            g1_byte <= g1_next;
            g2_byte <= g2_next;
            count   <= 3'd0;
            if (req_err || (req_mask == 4'd0)) begin
               done  <= 1'b1;
               error <= req_err;
            end else begin
               pending <= req_mask;
               state   <= EMIT;
            end
         end else if (handshake) begin
            pending <= pending & (pending - 4'd1);
            count   <= count + 3'd1;
            if (last) begin
               state <= IDLE;
               done  <= 1'b1;
            end
         end
      end
   end

   assign bus.o_req_ready  = (state == IDLE);
   assign bus.o_byte_valid = (state == EMIT);
   assign bus.o_byte       = cur_byte;
   assign bus.o_byte_last  = (state == EMIT) && last;
   assign bus.o_done       = done;
   assign bus.o_error      = error;
   assign bus.o_byte_count = count;
endmodule
